// File: rtl/vram_cpu_port_if.sv
// CPU/video/RAM signal bundle for the VRAM CPU port.
// slave: port side; master: CPU glue, video engine and RAM side.
interface vram_cpu_port_if #(
    parameter int STALL_W = 4,
    parameter int AW      = 14
) ();
    logic               ce;
    logic               cn;
    logic               rd;
    logic [12:0]        va;
    logic               req;
    logic               wr;
    logic [AW-1:0]      ca;
    logic [7:0]         cdi;
    logic [7:0]         cdo;
    logic               ack;
    logic               wait_n;
    logic [STALL_W-1:0] stall;
    logic [AW-1:0]      ma;
    logic [7:0]         mdo;
    logic [7:0]         mdi;
    logic               mwe;

    modport slave (
        input  ce, cn, rd, va,
        input  req, wr, ca, cdi, mdi,
        output cdo, ack, wait_n, stall,
        output ma, mdo, mwe
    );

    modport master (
        output ce, cn, rd, va,
        output req, wr, ca, cdi, mdi,
        input  cdo, ack, wait_n, stall,
        input  ma, mdo, mwe
    );
endinterface

// File: rtl/vram_cpu_port.sv
// CPU access port to the 16 KB screen RAM, sharing the bus with video.
// Ports: clock, reset (sync, active-low), bus (vram_cpu_port_if.slave).
module vram_cpu_port #(
    parameter int STALL_W = 4,
    parameter int AW      = 14
) (
    input  logic clock,
    input  logic reset,
    vram_cpu_port_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [STALL_W-1:0] SMAX = '1;

    logic [1:0]         state_q, state_d;
    logic               armed_q, armed_d;
    logic [AW-1:0]      addr_q,  addr_d;
    logic [7:0]         data_q,  data_d;
    logic               wr_q,    wr_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [7:0]         cdo_q,   cdo_d;

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        stall_d = stall_q;
        cdo_d   = cdo_q;
        if (bus.ce) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req && armed_q) begin
                        addr_d  = bus.ca;
                        data_d  = bus.cdi;
                        wr_d    = bus.wr;
                        stall_d = '0;
                        armed_d = 1'b0;
                        state_d = bus.cn ? WAIT : ACCESS;
                    end else if (!bus.req) begin
                        // Re-arm only once req is seen low.
                        armed_d = 1'b1;
                    end
                end
                WAIT: begin
                    if (stall_q != SMAX)
                        stall_d = stall_q + 1'b1;
                    if (!bus.cn && !bus.rd)
                        state_d = ACCESS;
                end
                ACCESS: begin
                    // A video fetch holds us here.
                    if (!bus.rd) begin
                        if (!wr_q)
                            cdo_d = bus.mdi;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            armed_q <= 1'b1;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            stall_q <= '0;
            cdo_q   <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            stall_q <= stall_d;
            cdo_q   <= cdo_d;
        end
    end

    logic in_acc;
    assign in_acc = (state_q == ACCESS);

    assign bus.ma     = in_acc ? addr_q
                               : {{(AW-13){1'b0}}, bus.va};
    assign bus.mwe    = in_acc && wr_q && !bus.rd;
    assign bus.mdo    = data_q;
    assign bus.ack    = (state_q == DONE);
    assign bus.wait_n = (state_q == IDLE) || (state_q == DONE);
    assign bus.stall  = stall_q;
    assign bus.cdo    = cdo_q;
endmodule
